// File: rtl/gb_wr_ctrl_rr.sv
`default_nettype none
// ============================================================================
// Module  : gb_wr_ctrl_rr
// Brief   : Round-robin global-buffer SRAM write controller with windowed,
//           depth-wrapping write address generation.
// Revision: 1.0
// ============================================================================
module gb_wr_ctrl_rr #(
  parameter int SRAM_ADDRWIDTH = 9,
  parameter int NUM_REQ        = 16,
  parameter int ID_WIDTH       = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      SRAM_config_start,
  input  logic [NUM_REQ-1:0]        Wr_Req,
  input  logic [SRAM_ADDRWIDTH-1:0] CFG_base_addr,
  input  logic [SRAM_ADDRWIDTH:0]   CFG_wr_len,
  input  logic                      IFSRAM_Conf_rdy,
  output logic                      SRAMIF_Conf_val,
  input  logic                      IFSRAM_Wr_val,
  output logic                      SRAMIF_Wr_rdy,
  output logic [ID_WIDTH-1:0]       SRAMIF_Wr_ID,
  output logic                      write_en,
  output logic [SRAM_ADDRWIDTH-1:0] addr_Wr,
  output logic                      write_SRAM_done,
  output logic [NUM_REQ-1:0]        Wr_Done,
  output logic [1:0]                State_Wr,
  output logic                      busy
);

  localparam int DEPTH = 2 ** SRAM_ADDRWIDTH;
  localparam int LW    = SRAM_ADDRWIDTH + 1;

  typedef enum logic [1:0] {
    WR_IDLE      = 2'b00,
    WR_REQ_READY = 2'b01,
    WR_WRITE     = 2'b11
  } state_t;

  state_t                    state_q;
  logic [SRAM_ADDRWIDTH-1:0] addr_q;
  logic [ID_WIDTH-1:0]       id_q;
  logic [ID_WIDTH-1:0]       last_grant_q;
  logic [LW-1:0]             cnt_q;
  logic [LW-1:0]             len_q;
  logic [NUM_REQ-1:0]        wr_done_q;

  logic                      grant_vld_d;
  logic [ID_WIDTH-1:0]       grant_d;
  logic [NUM_REQ-1:0]        req_rot;
  logic                      last_beat;

  // Search upward starting one past the previous winner, wrapping at NUM_REQ.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_d     = '0;
    req_rot     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      req_rot = Wr_Req >> ((int'(last_grant_q) + i) % NUM_REQ);
      if (!grant_vld_d && req_rot[0]) begin
        grant_vld_d = 1'b1;
        grant_d     = ID_WIDTH'((int'(last_grant_q) + i) % NUM_REQ);
      end
    end
  end

  assign State_Wr        = state_q;
  assign busy            = (state_q != WR_IDLE);
  assign SRAMIF_Conf_val = (state_q == WR_REQ_READY);
  assign SRAMIF_Wr_rdy   = (state_q == WR_WRITE);
  assign write_en        = SRAMIF_Wr_rdy & IFSRAM_Wr_val;
  assign last_beat       = ((cnt_q + LW'(1)) == len_q);
  assign write_SRAM_done = write_en & last_beat & ~SRAM_config_start;
  assign SRAMIF_Wr_ID    = id_q;
  assign addr_Wr         = addr_q;
  assign Wr_Done         = wr_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WR_IDLE;
      addr_q       <= '0;
      id_q         <= '0;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      cnt_q        <= '0;
      len_q        <= '0;
      wr_done_q    <= '0;
    end else begin
      wr_done_q <= '0;
      if (SRAM_config_start) begin
        state_q      <= WR_IDLE;
        cnt_q        <= '0;
        addr_q       <= '0;
        last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      end else begin
        case (state_q)
          WR_IDLE: begin
            if (grant_vld_d) begin
              id_q         <= grant_d;
              last_grant_q <= grant_d;
              addr_q       <= CFG_base_addr;
              // A zero length encodes a full-depth transaction.
              len_q        <= (CFG_wr_len == '0) ? LW'(DEPTH) : CFG_wr_len;
              cnt_q        <= '0;
              state_q      <= WR_REQ_READY;
            end
          end
          WR_REQ_READY: begin
            if (IFSRAM_Conf_rdy) state_q <= WR_WRITE;
          end
          WR_WRITE: begin
            if (write_en) begin
              addr_q <= addr_q + 1'b1;
              cnt_q  <= cnt_q + 1'b1;
              if (last_beat) begin
                state_q   <= WR_IDLE;
                wr_done_q <= NUM_REQ'(1) << id_q;
              end
            end
          end
          default: state_q <= WR_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gb_wr_ctrl_rr.sv
`default_nettype none
// ============================================================================
// Module  : tb_gb_wr_ctrl_rr
// Brief   : Scoreboard bench for gb_wr_ctrl_rr (beats and completion pulses).
// Revision: 1.0
// ============================================================================
module tb_gb_wr_ctrl_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SRAM_config_start;
  logic [15:0] Wr_Req;
  logic [8:0]  CFG_base_addr;
  logic [9:0]  CFG_wr_len;
  logic        IFSRAM_Conf_rdy;
  logic        SRAMIF_Conf_val;
  logic        IFSRAM_Wr_val;
  logic        SRAMIF_Wr_rdy;
  logic [5:0]  SRAMIF_Wr_ID;
  logic        write_en;
  logic [8:0]  addr_Wr;
  logic        write_SRAM_done;
  logic [15:0] Wr_Done;
  logic [1:0]  State_Wr;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [8:0] addr;
    logic       done;
    logic [5:0] id;
  } beat_t;

  beat_t       exp_beats[$];
  logic [15:0] exp_done[$];

  gb_wr_ctrl_rr #(.SRAM_ADDRWIDTH(9), .NUM_REQ(16), .ID_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .SRAM_config_start(SRAM_config_start),
    .Wr_Req(Wr_Req), .CFG_base_addr(CFG_base_addr), .CFG_wr_len(CFG_wr_len),
    .IFSRAM_Conf_rdy(IFSRAM_Conf_rdy), .SRAMIF_Conf_val(SRAMIF_Conf_val),
    .IFSRAM_Wr_val(IFSRAM_Wr_val), .SRAMIF_Wr_rdy(SRAMIF_Wr_rdy),
    .SRAMIF_Wr_ID(SRAMIF_Wr_ID), .write_en(write_en), .addr_Wr(addr_Wr),
    .write_SRAM_done(write_SRAM_done), .Wr_Done(Wr_Done),
    .State_Wr(State_Wr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write beat and every completion pulse is matched in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (write_en) begin
        checks++;
        if (exp_beats.size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected actual addr=%0h id=%0h required none", addr_Wr, SRAMIF_Wr_ID);
        end else begin
          beat_t e;
          e = exp_beats.pop_front();
          if (addr_Wr !== e.addr || write_SRAM_done !== e.done || SRAMIF_Wr_ID !== e.id) begin
            failures++;
            $display("FAIL beat actual addr=%0h done=%0b id=%0h required addr=%0h done=%0b id=%0h",
                     addr_Wr, write_SRAM_done, SRAMIF_Wr_ID, e.addr, e.done, e.id);
          end
        end
      end else if (write_SRAM_done) begin
        failures++;
        $display("FAIL done_without_write actual=1 required=0");
      end
      if (Wr_Done != '0) begin
        checks++;
        if (exp_done.size() == 0) begin
          failures++;
          $display("FAIL wr_done_unexpected actual=%0h required none", Wr_Done);
        end else begin
          logic [15:0] d;
          d = exp_done.pop_front();
          if (Wr_Done !== d) begin
            failures++;
            $display("FAIL wr_done actual=%0h required=%0h", Wr_Done, d);
          end
        end
      end
    end
  end

  function automatic logic valbit(input logic [15:0] pat, input int patlen, input int c);
    logic [15:0] t;
    if (c >= patlen) return 1'b1;
    t = pat >> c;
    return t[0];
  endfunction

  task automatic run_txn(input logic [15:0] req, input logic [8:0] base, input logic [9:0] len,
                         input int beats, input int id, input int conf_wait,
                         input logic [15:0] pat, input int patlen, input int exp_cycles,
                         input bit keep);
    int    n;
    int    cyc;
    bit    ok;
    beat_t e;
    for (int b = 0; b < beats; b++) begin
      e.addr = 9'(int'(base) + b);
      e.done = (b == beats - 1);
      e.id   = 6'(id);
      exp_beats.push_back(e);
    end
    exp_done.push_back(16'(1) << id);
    Wr_Req          = req;
    CFG_base_addr   = base;
    CFG_wr_len      = len;
    IFSRAM_Conf_rdy = 1'b0;
    IFSRAM_Wr_val   = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge clk); #1;
      if (SRAMIF_Conf_val) ok = 1'b1;
    end
    check("grant_seen", 32'(ok), 32'd1);
    if (!ok) return;
    if (!keep) Wr_Req = '0;
    n = 0;
    while (SRAMIF_Conf_val && n < 50) begin
      n++;
      if (n == conf_wait) begin
        IFSRAM_Conf_rdy = 1'b1;
        IFSRAM_Wr_val   = valbit(pat, patlen, 0);
      end
      @(posedge clk); #1;
    end
    IFSRAM_Conf_rdy = 1'b0;
    check("conf_val_cycles", 32'(n), 32'(conf_wait));
    cyc = 1;
    while (cyc < 2000) begin
      @(posedge clk); #1;
      if (!busy) break;
      cyc++;
      IFSRAM_Wr_val = valbit(pat, patlen, cyc - 1);
    end
    IFSRAM_Wr_val = 1'b0;
    check("write_cycles", 32'(cyc), 32'(exp_cycles));
  endtask

  initial begin
    bit    ok;
    beat_t e;
    rst_n             = 1'b0;
    SRAM_config_start = 1'b0;
    Wr_Req            = '0;
    CFG_base_addr     = '0;
    CFG_wr_len        = '0;
    IFSRAM_Conf_rdy   = 1'b0;
    IFSRAM_Wr_val     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_state",    32'(State_Wr),        32'd0);
    check("rst_addr",     32'(addr_Wr),         32'd0);
    check("rst_id",       32'(SRAMIF_Wr_ID),    32'd0);
    check("rst_wr_done",  32'(Wr_Done),         32'd0);
    check("rst_busy",     32'(busy),            32'd0);
    check("rst_conf_val", 32'(SRAMIF_Conf_val), 32'd0);
    check("rst_wr_rdy",   32'(SRAMIF_Wr_rdy),   32'd0);

    // Single transaction, wrap-around window, full depth, valid gaps.
    run_txn(16'h0004, 9'h010, 10'd4,  4,   2, 3, 16'hFFFF, 0, 4,   1'b0);
    check("idle_after_single", 32'(State_Wr), 32'd0);
    run_txn(16'h0004, 9'h1F0, 10'd32, 32,  2, 1, 16'hFFFF, 0, 32,  1'b0);
    run_txn(16'h0001, 9'h000, 10'd0,  512, 0, 2, 16'hFFFF, 0, 512, 1'b0);
    run_txn(16'h0008, 9'h100, 10'd4,  4,   3, 1, 16'h0059, 7, 7,   1'b0);

    // Held requests 0 and 2 alternate (previous winner was 3).
    run_txn(16'h0005, 9'h020, 10'd2, 2, 0, 1, 16'hFFFF, 0, 2, 1'b1);
    run_txn(16'h0005, 9'h020, 10'd2, 2, 2, 1, 16'hFFFF, 0, 2, 1'b1);
    run_txn(16'h0005, 9'h020, 10'd2, 2, 0, 1, 16'hFFFF, 0, 2, 1'b1);
    run_txn(16'h0005, 9'h020, 10'd2, 2, 2, 1, 16'hFFFF, 0, 2, 1'b1);
    Wr_Req = '0;

    // Clear in idle restores requestor 0 as first priority.
    SRAM_config_start = 1'b1;
    @(posedge clk); #1;
    SRAM_config_start = 1'b0;
    for (int g = 0; g <= 16; g++)
      run_txn(16'hFFFF, 9'(g * 3), 10'd1, 1, g % 16, 1, 16'hFFFF, 0, 1, 1'b1);
    Wr_Req = '0;

    // Abort on beat 5 of a 16-beat transaction, request 1 still asserted.
    for (int b = 0; b < 5; b++) begin
      e.addr = 9'(9'h040 + b); e.done = 1'b0; e.id = 6'd1;
      exp_beats.push_back(e);
    end
    Wr_Req          = 16'h0002;
    CFG_base_addr   = 9'h040;
    CFG_wr_len      = 10'd16;
    IFSRAM_Conf_rdy = 1'b1;
    IFSRAM_Wr_val   = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge clk); #1;
      if (SRAMIF_Wr_rdy) ok = 1'b1;
    end
    check("abort_write_seen", 32'(ok), 32'd1);
    repeat (4) begin @(posedge clk); #1; end
    SRAM_config_start = 1'b1;
    @(posedge clk); #1;
    SRAM_config_start = 1'b0;
    check("abort_state",   32'(State_Wr), 32'd0);
    check("abort_addr",    32'(addr_Wr),  32'd0);
    check("abort_no_done", 32'(Wr_Done),  32'd0);
    for (int b = 0; b < 16; b++) begin
      e.addr = 9'(9'h040 + b); e.done = (b == 15); e.id = 6'd1;
      exp_beats.push_back(e);
    end
    exp_done.push_back(16'h0002);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(posedge clk); #1;
      if (SRAMIF_Conf_val || SRAMIF_Wr_rdy) ok = 1'b1;
    end
    check("regrant_seen", 32'(ok), 32'd1);
    Wr_Req = '0;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(posedge clk); #1;
      if (!busy) ok = 1'b1;
    end
    check("regrant_complete", 32'(ok), 32'd1);
    IFSRAM_Conf_rdy = 1'b0;
    IFSRAM_Wr_val   = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    check("beats_drained", 32'(exp_beats.size()), 32'd0);
    check("dones_drained", 32'(exp_done.size()),  32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gb_wr_ctrl_rr.md
Name: gb_wr_ctrl_rr

Overview:
Parametrised global-buffer SRAM write controller.
- Arbitrates round-robin among NUM_REQ write requestors.
- Runs the conf/write handshake with the SRAM interface.
- Generates SRAM write addresses over a programmable window (base address plus length), wrapping modulo the SRAM depth.
- Sits between the GB request logic and the SRAM bank interface. Replaces the fixed full-depth, externally-ID'd write controller.

Parameters:
SRAM_ADDRWIDTH, 9, SRAM address width; DEPTH = 2**SRAM_ADDRWIDTH
NUM_REQ, 16, number of write requestors
ID_WIDTH, 6, width of SRAMIF_Wr_ID; must satisfy 2**ID_WIDTH >= NUM_REQ
WR_IDLE / WR_REQ_READY / WR_WRITE, 2'b00 / 2'b01 / 2'b11, state encodings

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
SRAM_config_start  in  1  synchronous abort/clear, highest priority
Wr_Req  in  NUM_REQ  per-requestor write request, level
CFG_base_addr  in  SRAM_ADDRWIDTH  first write address, sampled at grant
CFG_wr_len  in  SRAM_ADDRWIDTH+1  beats per transaction, sampled at grant; 0 means DEPTH
IFSRAM_Conf_rdy  in  1  SRAM interface accepts configuration
SRAMIF_Conf_val  out  1  configuration valid
IFSRAM_Wr_val  in  1  write data valid
SRAMIF_Wr_rdy  out  1  controller ready for write data
SRAMIF_Wr_ID  out  ID_WIDTH  granted requestor index, zero-extended
write_en  out  1  SRAM write strobe
addr_Wr  out  SRAM_ADDRWIDTH  SRAM write address
write_SRAM_done  out  1  last beat of the current transaction
Wr_Done  out  NUM_REQ  one-hot completion pulse to the granted requestor
State_Wr  out  2  current state
busy  out  1  State_Wr != WR_IDLE

Behaviour:
- Reset values: State_Wr=WR_IDLE; addr_Wr, SRAMIF_Wr_ID, Wr_Done, beat counter all 0; last_grant=NUM_REQ-1, so requestor 0 has first priority.
- Outputs are combinational from state:
  - SRAMIF_Conf_val = (State_Wr==WR_REQ_READY).
  - SRAMIF_Wr_rdy = (State_Wr==WR_WRITE).
  - write_en = SRAMIF_Wr_rdy & IFSRAM_Wr_val.
- WR_IDLE:
  - If SRAM_config_start is high, stay in WR_IDLE.
  - Else if |Wr_Req, grant the first set bit searching upward from last_grant+1 (mod NUM_REQ).
  - At grant, register SRAMIF_Wr_ID=grant, last_grant=grant, addr_Wr=CFG_base_addr, len=(CFG_wr_len==0 ? DEPTH : CFG_wr_len), counter=0. Move to WR_REQ_READY.
- WR_REQ_READY: on IFSRAM_Conf_rdy, move to WR_WRITE. Else hold indefinitely.
- WR_WRITE:
  - On each write_en, addr_Wr <= addr_Wr+1 (natural wrap 2**SRAM_ADDRWIDTH-1 -> 0) and counter <= counter+1.
  - write_SRAM_done = write_en & (counter==len-1), combinational.
  - On write_SRAM_done, move to WR_IDLE.
- Wr_Done: Wr_Done[SRAMIF_Wr_ID] is registered and pulses exactly 1 cycle, the cycle after write_SRAM_done.
- Request changes: deasserting Wr_Req after grant does not cancel the transaction. Requests are only sampled in WR_IDLE.
- Back-to-back transactions: at least 1 WR_IDLE cycle separates consecutive grants. No beat is lost; the next grant may occur in the same cycle Wr_Done pulses.
- IFSRAM_Wr_val gaps: addr_Wr and the counter hold. There is no timeout.
- SRAM_config_start in any state:
  - Next state is WR_IDLE; counter and addr_Wr clear to 0; last_grant returns to NUM_REQ-1.
  - No Wr_Done is generated, and write_SRAM_done is suppressed that cycle.
  - write_en still follows state and valid in that cycle. The SRAM side must ignore it.
- SRAMIF_Wr_ID and addr_Wr never change except at grant, on write_en, or on clear.

Test Plan:
- Single transaction: Wr_Req=0x0004, base=0x010, len=4, Conf_rdy after 3 cycles, Wr_val constant -> Conf_val high 3 cycles; ID=2; addresses 0x010..0x013; done on 4th beat; Wr_Done=0x0004 one cycle later; back to IDLE.
- Wrap: base=0x1F0, len=32 -> addresses 0x1F0..0x1FF then 0x000..0x00F; exactly 32 write_en; done coincides with address 0x00F.
- Full depth: len=0 -> 512 beats, addresses 0x000..0x1FF from base 0; done on beat 512 only.
- Round-robin: Wr_Req=0x0005 held after reset -> grants in order 0, 2, 0, 2; Wr_Req=0xFFFF -> grants 0, 1, 2, ... 15, 0.
- Valid gaps: Wr_val pattern 1,0,0,1,1,0,1 with len=4 -> addr_Wr advances only on valid cycles; done on the 7th cycle.
- Abort: SRAM_config_start at beat 5 of len=16 -> next cycle IDLE, addr_Wr=0, no Wr_Done; with Wr_Req=0x0002 still high, next grant is ID=1 and addresses restart at base.
